// File: rtl/gpio_console_capture.sv
// Console capture: edge-detects the GPIO3 character strobe into a FIFO drained over
// valid/ready, and latches the GPIO4 exit code, raising done once all output has drained.
module gpio_console_capture #(
   parameter  int unsigned DEPTH  = 16,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        char_data,
   input  logic              char_update,
   input  logic [7:0]        exit_data,
   input  logic              exit_update,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W:0]   fill_level,
   output logic              overflow,
   output logic [7:0]        drop_count,
   output logic [7:0]        exit_code,
   output logic              done
);

   localparam int unsigned FILL_W   = ADDR_W + 1;
   localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PENDING = 2'd1,
      S_DONE    = 2'd2
   } exit_state_t;

   logic              r_char_upd_q;
   logic              r_exit_upd_q;
   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [FILL_W-1:0] r_fill;
   logic              r_out_valid;
   logic [7:0]        r_out_data;
   logic              r_overflow;
   logic [7:0]        r_drop_count;
   logic [7:0]        r_exit_code;
   logic              r_done;
   exit_state_t       r_state;

   logic              w_char_rise;
   logic              w_exit_rise;
   logic              w_pop;
   logic              w_full;
   logic              w_push;
   logic              w_drop;
   logic [ADDR_W-1:0] w_rd_ptr_nxt;
   logic [FILL_W-1:0] w_fill_nxt;
   logic [7:0]        w_head_nxt;
   exit_state_t       w_next_state;
   logic              w_exit_load;

   assign w_char_rise = char_update & ~r_char_upd_q;
   assign w_exit_rise = exit_update & ~r_exit_upd_q;
   assign w_pop       = r_out_valid & out_ready;
   assign w_full      = (r_fill == FULL_LVL);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
   assign w_push      = w_char_rise & (~w_full | w_pop);
   assign w_drop      = w_char_rise & w_full & ~w_pop;

   assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + ADDR_W'(1)) : r_rd_ptr;

   always_comb begin
      w_fill_nxt = r_fill;
      case ({w_push, w_pop})
         2'b10:   w_fill_nxt = r_fill + FILL_W'(1);
         2'b01:   w_fill_nxt = r_fill - FILL_W'(1);
         default: w_fill_nxt = r_fill;
      endcase
   end

   // Registered head: a byte landing on the next read slot is forwarded from the input.
   always_comb begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
         w_head_nxt = char_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= char_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_char_upd_q <= 1'b1;
         r_exit_upd_q <= 1'b1;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fill       <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         r_char_upd_q <= char_update;
         r_exit_upd_q <= exit_update;
         r_rd_ptr     <= w_rd_ptr_nxt;
         r_fill       <= w_fill_nxt;
         r_out_valid  <= (w_fill_nxt != '0);
         r_out_data   <= w_head_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) begin
               r_drop_count <= r_drop_count + 8'd1;
            end
         end
      end
   end

   // Exit sequencing: state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_exit_code <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= (w_next_state == S_DONE);
         if (w_exit_load) begin
            r_exit_code <= exit_data;
         end
      end
   end

   // Exit sequencing: a byte pushed this cycle keeps PENDING alive until it drains.
   always_comb begin
      w_next_state = r_state;
      w_exit_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_exit_rise) begin
               w_exit_load  = 1'b1;
               w_next_state = S_PENDING;
            end
         end
         S_PENDING: begin
            if ((r_fill == '0) && !w_char_rise) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE:  w_next_state = S_DONE;
         default: w_next_state = S_IDLE;
      endcase
   end

   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign fill_level = r_fill;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;
   assign exit_code  = r_exit_code;
   assign done       = r_done;

endmodule

// File: tb/tb_gpio_console_capture.sv
// Bench for gpio_console_capture: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gpio_console_capture;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] char_data;
   logic       char_update;
   logic [7:0] exit_data;
   logic       exit_update;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] fill_level;
   logic       overflow;
   logic [7:0] drop_count;
   logic [7:0] exit_code;
   logic       done;

   gpio_console_capture #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .char_data(char_data), .char_update(char_update),
      .exit_data(exit_data), .exit_update(exit_update),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count),
      .exit_code(exit_code), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the FIFO is a plain queue, exit progress is two flags.
   logic [7:0] m_q[$];
   logic [7:0] got[$];
   bit         m_init = 0;
   bit         m_ovf;
   int         m_drop;
   logic [7:0] m_code;
   bit         m_pending;
   bit         m_done;
   bit         m_pc, m_pe;
   bit         m_crise, m_erise, m_pop;
   int         m_n0;

   always @(posedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
      if (rst) begin
         m_q.delete();
         m_ovf = 0; m_drop = 0; m_code = 8'h00;
         m_pending = 0; m_done = 0;
         m_pc = 1; m_pe = 1;
         m_init = 1;
      end else if (m_init) begin
         m_crise = char_update && !m_pc;
         m_erise = exit_update && !m_pe;
         m_n0    = m_q.size();
         m_pop   = (m_n0 > 0) && out_ready;
         if (m_pop) void'(m_q.pop_front());
         if (m_crise) begin
            if (m_n0 < DEPTH || m_pop) m_q.push_back(char_data);
            else begin
               m_ovf = 1;
               if (m_drop < 255) m_drop++;
            end
         end
         if (!m_pending && !m_done) begin
            if (m_erise) begin m_code = exit_data; m_pending = 1; end
         end else if (m_pending) begin
            if (m_n0 == 0 && !m_crise) begin m_pending = 0; m_done = 1; end
         end
         m_pc = char_update;
         m_pe = exit_update;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("m_valid", 32'(out_valid), 32'(m_q.size() > 0));
         chk("m_fill", 32'(fill_level), 32'(m_q.size()));
         if (m_q.size() > 0) chk("m_data", 32'(out_data), 32'(m_q[0]));
         chk("m_ovf", 32'(overflow), 32'(m_ovf));
         chk("m_drop", 32'(drop_count), 32'(m_drop));
         chk("m_code", 32'(exit_code), 32'(m_code));
         chk("m_done", 32'(done), 32'(m_done));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push_byte(input logic [7:0] b);
      char_data = b; char_update = 1'b1;
      step();
      char_update = 1'b0;
      step();
   endtask

   task automatic exit_pulse(input logic [7:0] c);
      exit_data = c; exit_update = 1'b1;
      step();
      exit_update = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; char_data = 8'h00; char_update = 1'b1;
      exit_data = 8'h00; exit_update = 1'b0; out_ready = 1'b0;

      // Strobe held high through reset release must not push.
      repeat (3) step();
      rst = 1'b0;
      repeat (3) step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_fill", 32'(fill_level), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      chk("rst_code", 32'(exit_code), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      char_update = 1'b0;
      step();

      // Single byte.
      char_data = 8'h41; char_update = 1'b1;
      step();
      chk("one_valid", 32'(out_valid), 32'd1);
      chk("one_data", 32'(out_data), 32'h41);
      chk("one_fill", 32'(fill_level), 32'd1);
      char_update = 1'b0; out_ready = 1'b1;
      step();
      chk("one_pop_valid", 32'(out_valid), 32'd0);
      chk("one_pop_fill", 32'(fill_level), 32'd0);

      // Ordering and pointer wrap while draining.
      got.delete();
      for (int i = 0; i < 48; i++) push_byte(8'(i));
      repeat (3) step();
      chk("wrap_count", 32'(got.size()), 32'd48);
      for (int i = 0; i < 48 && i < got.size(); i++) chk("wrap_order", 32'(got[i]), 32'(i));
      chk("wrap_ovf", 32'(overflow), 32'd0);

      // Overflow.
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) push_byte(8'(8'h10 + i));
      chk("ovf_fill", 32'(fill_level), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_drop", 32'(drop_count), 32'd4);
      got.delete();
      out_ready = 1'b1;
      repeat (20) step();
      out_ready = 1'b0;
      chk("ovf_drain_count", 32'(got.size()), 32'd16);
      for (int i = 0; i < 16 && i < got.size(); i++) chk("ovf_drain", 32'(got[i]), 32'(8'h10 + i));

      // Full plus simultaneous pop: push accepted.
      for (int i = 0; i < 16; i++) push_byte(8'(8'h50 + i));
      chk("full_fill", 32'(fill_level), 32'd16);
      got.delete();
      char_data = 8'h99; char_update = 1'b1; out_ready = 1'b1;
      step();
      chk("fullpop_fill", 32'(fill_level), 32'd16);
      chk("fullpop_drop", 32'(drop_count), 32'd4);
      char_update = 1'b0;
      repeat (20) step();
      out_ready = 1'b0;
      chk("fullpop_count", 32'(got.size()), 32'd17);
      if (got.size() == 17) begin
         chk("fullpop_first", 32'(got[0]), 32'h50);
         chk("fullpop_last", 32'(got[16]), 32'h99);
      end

      // Exit ordering: done one cycle after the FIFO empties.
      push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
      exit_pulse(8'h07);
      chk("exit_code", 32'(exit_code), 32'h07);
      chk("exit_not_done", 32'(done), 32'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 40 && fill_level != 5'd0; k++) step();
      chk("exit_drained", 32'(fill_level), 32'd0);
      chk("exit_done_lag", 32'(done), 32'd0);
      step();
      chk("exit_done", 32'(done), 32'd1);
      out_ready = 1'b0;
      exit_pulse(8'h09);
      chk("exit_hold", 32'(exit_code), 32'h07);
      chk("exit_done_hold", 32'(done), 32'd1);

      // Mid-operation reset with bytes queued and exit pending.
      rst = 1'b1; step(); rst = 1'b0; step();
      for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i));
      exit_pulse(8'h22);
      chk("mid_code", 32'(exit_code), 32'h22);
      chk("mid_fill", 32'(fill_level), 32'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_fill", 32'(fill_level), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_code", 32'(exit_code), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      step();

      // Exit with an empty FIFO: done two cycles after the edge.
      exit_data = 8'h05; exit_update = 1'b1;
      step();
      exit_update = 1'b0;
      chk("empty_exit_code", 32'(exit_code), 32'h05);
      chk("empty_exit_n1", 32'(done), 32'd0);
      step();
      chk("empty_exit_n2", 32'(done), 32'd1);

      // Simultaneous character and exit edges: the byte must drain first.
      rst = 1'b1; step(); rst = 1'b0; step();
      char_data = 8'hAB; char_update = 1'b1; exit_data = 8'h03; exit_update = 1'b1;
      step();
      char_update = 1'b0; exit_update = 1'b0;
      step(); step();
      chk("both_fill", 32'(fill_level), 32'd1);
      chk("both_not_done", 32'(done), 32'd0);
      out_ready = 1'b1;
      step();
      chk("both_drained", 32'(fill_level), 32'd0);
      chk("both_done_lag", 32'(done), 32'd0);
      step();
      chk("both_done", 32'(done), 32'd1);
      out_ready = 1'b0;
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
